// File: rtl/otter_mem_pkg.sv
// Shared memory-side definitions for the cache controller, burst master and memory model.
// Holds line geometry and the burst sequencing states.
package otter_mem_pkg;

  localparam int WORD_W        = 32;
  localparam int BURST_LEN     = 4;
  localparam int LINE_W        = WORD_W * BURST_LEN;
  localparam int LINE_OFF_BITS = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } burst_state_t;

  typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/line_burst_master.sv
// Whole-line burst initiator toward single-port main memory: fills assemble BURST_LEN beats
// into one line, writebacks stream a buffered line out one beat per MEMVALID.
module line_burst_master #(
  parameter int WORD_W    = otter_mem_pkg::WORD_W,
  parameter int BURST_LEN = otter_mem_pkg::BURST_LEN,
  parameter int ADDR_W    = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [WORD_W*BURST_LEN-1:0] req_line,
  output logic                        resp_valid,
  output logic [WORD_W*BURST_LEN-1:0] resp_line,
  output logic                        busy,
  output logic                        RE,
  output logic                        WE,
  output logic [ADDR_W-1:0]           ADDR,
  output logic [WORD_W-1:0]           DATA_IN,
  input  logic [WORD_W-1:0]           DATA_OUT,
  input  logic                        MEMVALID
);
  import otter_mem_pkg::*;

  localparam int LINE_BITS = WORD_W * BURST_LEN;
  localparam int LB        = $clog2(LINE_BITS / 8);
  localparam int BEAT_W    = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = {{(ADDR_W-LB){1'b0}}, {LB{1'b1}}};

  burst_state_t          state_reg;
  logic [BEAT_W-1:0]     beat_reg;
  logic [LINE_BITS-1:0]  wbuf_reg;
  logic [LINE_BITS-1:0]  fill_reg;
  logic [LINE_BITS-1:0]  fill_next;
  logic [WORD_W-1:0]     wbuf_word [BURST_LEN];

  // fill_next is the assembly register with the current beat merged in, so the
  // final beat lands in resp_line on the same edge that enters RESP.
  generate
    for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_words
      assign wbuf_word[gi] = wbuf_reg[gi*WORD_W +: WORD_W];
      assign fill_next[gi*WORD_W +: WORD_W] =
        (beat_reg == BEAT_W'(gi)) ? DATA_OUT : fill_reg[gi*WORD_W +: WORD_W];
    end
  endgenerate

  assign DATA_IN   = (state_reg == WR) ? wbuf_word[beat_reg] : '0;
  assign busy      = (state_reg != IDLE);
  assign req_ready = (state_reg == IDLE) && !RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= IDLE;
      beat_reg   <= '0;
      wbuf_reg   <= '0;
      fill_reg   <= '0;
      resp_line  <= '0;
      resp_valid <= 1'b0;
      RE         <= 1'b0;
      WE         <= 1'b0;
      ADDR       <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            ADDR      <= req_addr & ~OFF_MASK;
            wbuf_reg  <= req_line;
            beat_reg  <= '0;
            RE        <= !req_we;
            WE        <= req_we;
            state_reg <= req_we ? WR : RD;
          end
        end
        RD: begin
          if (MEMVALID) begin
            fill_reg <= fill_next;
            beat_reg <= beat_reg + BEAT_W'(1);
            if (beat_reg == LAST_BEAT) begin
              RE         <= 1'b0;
              resp_line  <= fill_next;
              resp_valid <= 1'b1;
              state_reg  <= RESP;
            end
          end
        end
        WR: begin
          if (MEMVALID) begin
            beat_reg <= beat_reg + BEAT_W'(1);
            if (beat_reg == LAST_BEAT) begin
              WE         <= 1'b0;
              resp_valid <= 1'b1;
              state_reg  <= RESP;
            end
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/line_burst_master.md
Name: line_burst_master

Overview:
- Burst initiator between the L1 cache controller and single-port main memory, on the memory-side end of the burst protocol.
- Accepts one whole-line request: a fill (read) or a writeback (write).
- Drives the memory's RE/WE/ADDR/DATA_IN and sequences BURST_LEN word beats, counting beats on MEMVALID.
- For a fill, assembles the returned beats into one line and hands it back to the cache controller with a single-cycle response pulse.

Parameters:
- WORD_W, 32, bits per memory beat/word.
- BURST_LEN, 4, beats per cache line; must be a power of two ≥2.
- ADDR_W, 32, byte-address width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- req_valid  in  1  cache controller requests a line transfer.
- req_ready  out  1  adapter idle; request accepted when req_valid&&req_ready.
- req_we  in  1  1=writeback line, 0=fill line.
- req_addr  in  ADDR_W  byte address anywhere inside target line.
- req_line  in  WORD_W*BURST_LEN  writeback data; word k at bits [k*WORD_W +: WORD_W].
- resp_valid  out  1  one-cycle pulse: transfer complete.
- resp_line  out  WORD_W*BURST_LEN  filled line; valid during resp_valid and held until the next fill completes.
- busy  out  1  transfer in progress (state≠IDLE).
- RE  out  1  memory read enable.
- WE  out  1  memory write enable.
- ADDR  out  ADDR_W  line-aligned memory address.
- DATA_IN  out  WORD_W  write beat to memory.
- DATA_OUT  in  WORD_W  read beat from memory.
- MEMVALID  in  1  memory beat strobe; one beat per high cycle.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, beat=0.
  - RE=0, WE=0, ADDR=0, DATA_IN=0.
  - resp_valid=0, resp_line=0, busy=0, req_ready=1 once RST deasserts.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - On accept: latch line address {req_addr[ADDR_W-1:LB],LB'b0}, where LB=log2(BURST_LEN*WORD_W/8) (=4 by default).
  - On accept, also latch req_line into a write buffer and set beat=0.
  - Next state is WR if req_we, else RD.
  - MEMVALID in IDLE is ignored.
- RD:
  - RE=1 and ADDR stable for the entire state; WE=0.
  - On each MEMVALID cycle: store DATA_OUT into line word [beat], then beat++.
  - On the MEMVALID where beat==BURST_LEN-1: go to RESP; RE drops on the next cycle.
  - Memory latency (DELAY_CYCLES) is arbitrary; the adapter waits indefinitely with no timeout.
- WR:
  - WE=1, RE=0, ADDR stable.
  - DATA_IN = buffer word [beat], combinational from the registered beat.
  - On each MEMVALID cycle the memory has consumed the current beat: beat++.
  - After the last beat: go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; then IDLE.
  - For a fill, resp_line updates in the same edge that enters RESP, so it is valid with resp_valid.
  - For a writeback, resp_line is unchanged.
- Mutual exclusion:
  - req_ready=0 in RD/WR/RESP; req_valid there is not accepted and must be held by the requester.
  - RE and WE are never high in the same cycle.
- Latency:
  - Accept edge → RE/WE high the next cycle.
  - Last MEMVALID → resp_valid the next cycle.
  - Minimum request-to-response = BURST_LEN+2 cycles.
- Counter: beat is log2(BURST_LEN) bits and wraps to 0 after the last beat. It is not otherwise reset except by RST or a new accept.
- Back-to-back: a new request can be accepted in the cycle after RESP (IDLE). There is no accept in the RESP cycle itself.
- Reset mid-burst: all enables drop asynchronously and the partial line is discarded. No resp_valid is produced for the aborted request.

Decomposition:
- Shared package otter_mem_pkg holds:
  - localparams WORD_W, BURST_LEN, LINE_W=WORD_W*BURST_LEN, LINE_OFF_BITS.
  - the enum typedef for the burst states {IDLE,RD,WR,RESP}.
  - typedef line_t = logic [LINE_W-1:0].
- The package is also used by the cache controller and the memory model.
- No sub-module is required; the beat counter and assembly register are inline.

Test Plan:
- Fill, default params, memory with DELAY_CYCLES=10 returning 0xA0,0xA1,0xA2,0xA3:
  - req_addr=0x0000_1238, req_we=0 → ADDR=0x0000_1230, RE=1 throughout the burst.
  - resp_valid one cycle after 4th MEMVALID, resp_line=0x000000A3_000000A2_000000A1_000000A0.
- Writeback, req_addr=0x40, req_line words {0x11,0x22,0x33,0x44} (word0=0x11):
  - memory sees WE=1, ADDR=0x40, DATA_IN 0x11,0x22,0x33,0x44 on successive MEMVALID cycles.
  - one resp_valid; RE stays 0.
- Gapped MEMVALID (pattern 1,0,0,1,0,1,1) during a fill:
  - exactly 4 beats captured in order; req_ready stays 0 until after resp_valid.
- req_valid held high during a busy fill with a second request (req_we=1, addr 0x80):
  - not accepted until IDLE.
  - second burst starts with WE=1, ADDR=0x80 two cycles after the first resp_valid.
- RST asserted after 2 of 4 read beats:
  - RE=0 same cycle (async), busy=0, resp_valid never pulses.
  - a subsequent fill completes normally with correct data.
- MEMVALID pulsed while IDLE:
  - no state change, no resp_valid, resp_line unchanged.
